register_bank: RTL and testbench

//   Parametrised bank of NUM_REGS general-purpose registers, WIDTH bits each, sharing one
//   3-bit FunSel op set (dec/inc/load/clear/half-word writes/sign-extend).

---
 rtl/register_bank_pkg.sv | 20 ++
 rtl/reg_next_calc.sv | 43 ++++
 rtl/register_bank.sv | 82 ++++++++
 tb/tb_register_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - FunSel op encodings and helpers shared by the register bank
package register_bank_pkg;

  typedef enum logic [2:0] {
    FS_DEC  = 3'b000,
    FS_INC  = 3'b001,
    FS_LOAD = 3'b010,
    FS_CLR  = 3'b011,
    FS_CLRL = 3'b100,
    FS_WRL  = 3'b101,
    FS_WRH  = 3'b110,
    FS_SEXT = 3'b111
  } funsel_t;

  // Only the counting ops can wrap; every other op forces the wrap flag low.
  function automatic logic is_count_op(input funsel_t fs);
    return (fs == FS_INC) || (fs == FS_DEC);
  endfunction

endpackage

// File: rtl/reg_next_calc.sv
// rtl/reg_next_calc.sv - next-state value and wrap detect for one register
module reg_next_calc
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_hit
);

  localparam int HALF = WIDTH / 2;

  funsel_t fs;
  assign fs = funsel_t'(FunSel);

  // Next value of the register if this op were applied at the coming edge.
  always_comb begin
    nxt = cur;
    case (fs)
      FS_DEC:  nxt = cur - 1'b1;
      FS_INC:  nxt = cur + 1'b1;
      FS_LOAD: nxt = I;
      FS_CLR:  nxt = '0;
      FS_CLRL: nxt = {{HALF{1'b0}}, I[HALF-1:0]};
      FS_WRL:  nxt = {cur[WIDTH-1:HALF], I[HALF-1:0]};
      FS_WRH:  nxt = {I[HALF-1:0], cur[HALF-1:0]};
      FS_SEXT: nxt = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
      default: nxt = cur;
    endcase
  end

  // Wrap occurs when INC leaves all-ones or DEC leaves zero.
  always_comb begin
    wrap_hit = 1'b0;
    if (is_count_op(fs)) begin
      wrap_hit = (fs == FS_INC) ? (&cur) : (cur == '0);
    end
  end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - multi-register bank with two read ports, wrap flag, optional REG_BANK_FWD_EN forwarding
module register_bank
  import register_bank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_REGS-1:0] RegEn,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic                Wrap
);

  logic [WIDTH-1:0]    r    [NUM_REGS];
  logic [WIDTH-1:0]    nxt  [NUM_REGS];
  logic [WIDTH-1:0]    view [NUM_REGS];
  logic [NUM_REGS-1:0] hit;

  // One next-state calculator per register; the same result feeds writes and forwarding.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_calc
    reg_next_calc #(
      .WIDTH(WIDTH)
    ) u_calc (
      .cur      (r[g]),
      .I        (I),
      .FunSel   (FunSel),
      .nxt      (nxt[g]),
      .wrap_hit (hit[g])
    );
  end

  // Register array: each enabled register takes its computed next value.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) r[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (RegEn[k]) r[k] <= nxt[k];
      end
    end
  end

  // Wrap flag: non-count ops yield no hits, so OR of enabled hits covers every op; idle cycles hold.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Wrap <= 1'b0;
    end else if (|RegEn) begin
      Wrap <= |(RegEn & hit);
    end
  end

`ifdef REG_BANK_FWD_EN
  // Forwarding: an enabled register is seen with its pending value in the same cycle.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) view[k] = RegEn[k] ? nxt[k] : r[k];
  end
`else
  // No forwarding: readers always see stored contents.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) view[k] = r[k];
  end
`endif

  // Read ports: compare against every index so out-of-range selects fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(OutASel) == k) OutA = view[k];
      if (int'(OutBSel) == k) OutB = view[k];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed scoreboard bench for register_bank
module tb_register_bank;

  localparam int W = 16;
  localparam int N = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [N-1:0] RegEn;
  logic [2:0]   FunSel;
  logic [W-1:0] I;
  logic [1:0]   OutASel;
  logic [1:0]   OutBSel;
  logic [W-1:0] OutA;
  logic [W-1:0] OutB;
  logic         Wrap;

  register_bank #(.WIDTH(W), .NUM_REGS(N), .RESET_VAL('0)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .RegEn   (RegEn),
    .FunSel  (FunSel),
    .I       (I),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB),
    .Wrap    (Wrap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string        tag;
    int           kind;
    int           sel;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m [N];
  logic         mw;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int sel, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag);
    for (int k = 0; k < N; k++) begin
      push($sformatf("%s_A%0d", tag, k), 0, k, m[k]);
      push($sformatf("%s_B%0d", tag, k), 1, N - 1 - k, m[N - 1 - k]);
    end
    push({tag, "_wrap"}, 2, 0, {{(W-1){1'b0}}, mw});
  endtask

  task automatic drain();
    exp_t         e;
    logic [W-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = '0;
      case (e.kind)
        0:       begin OutASel = 2'(e.sel); #1 obs = OutA; end
        1:       begin OutBSel = 2'(e.sel); #1 obs = OutB; end
        default: begin #1 obs = {{(W-1){1'b0}}, Wrap}; end
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic [2:0] fs,
                                              input logic [W-1:0] d);
    case (fs)
      3'd0:    return cur - 16'd1;
      3'd1:    return cur + 16'd1;
      3'd2:    return d;
      3'd3:    return 16'h0000;
      3'd4:    return {8'h00, d[7:0]};
      3'd5:    return {cur[15:8], d[7:0]};
      3'd6:    return {d[7:0], cur[7:0]};
      default: return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m[k] = '0;
    mw = 1'b0;
  endtask

  // One clocked operation; RegEn drops right after the edge so draining may span edges.
  task automatic op(input logic [N-1:0] en, input logic [2:0] fs, input logic [W-1:0] d,
                    input string tag);
    logic [W-1:0] nm [N];
    logic         any;
    @(negedge Clock);
    RegEn = en; FunSel = fs; I = d;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      nm[k] = en[k] ? model_next(m[k], fs, d) : m[k];
      if (en[k] && ((fs == 3'd1 && m[k] == 16'hFFFF) || (fs == 3'd0 && m[k] == 16'h0000)))
        any = 1'b1;
    end
    @(posedge Clock);
    #1 RegEn = '0;
    for (int k = 0; k < N; k++) m[k] = nm[k];
    if (en != '0) mw = any;
    push_model(tag);
  endtask

  initial begin
    Reset = 1'b1; RegEn = '0; FunSel = 3'd0; I = '0; OutASel = 2'd0; OutBSel = 2'd0;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    push("rst_A0", 0, 0, 16'h0000);
    push("rst_B3", 1, 3, 16'h0000);
    push("rst_wrap", 2, 0, 16'h0000);
    push_model("rst");
    drain();
    Reset = 1'b0;

    op(4'b1111, 3'd2, 16'h1234, "load_all");
    push("load_all_R2", 0, 2, 16'h1234);
    drain();

    @(negedge Clock);
    #1 Reset = 1'b1;
    OutASel = 2'd0; OutBSel = 2'd3;
    #1;
    chk("async_rst_A", OutA, 16'h0000);
    chk("async_rst_B", OutB, 16'h0000);
    Reset = 1'b0;
    model_reset();

    op(4'b0001, 3'd2, 16'hFFFF, "load_ffff");
    drain();
    op(4'b0001, 3'd1, 16'h0000, "inc_wrap");
    push("inc_wrap_R0", 0, 0, 16'h0000);
    push("inc_wrap_flag", 2, 0, 16'h0001);
    drain();
    op(4'b0001, 3'd2, 16'h0000, "load_clears_wrap");
    push("load_clears_wrap_flag", 2, 0, 16'h0000);
    drain();
    for (int n = 0; n < 3; n++) begin
      op(4'b0000, 3'd1, 16'hFFFF, $sformatf("idle%0d", n));
      push($sformatf("idle%0d_hold", n), 2, 0, 16'h0000);
      drain();
    end

    op(4'b0110, 3'd7, 16'h0080, "sext");
    push("sext_R1", 0, 1, 16'hFF80);
    push("sext_R2", 1, 2, 16'hFF80);
    drain();
    op(4'b0010, 3'd6, 16'h0012, "wrh");
    push("wrh_R1", 0, 1, 16'h1280);
    push("wrh_R2", 0, 2, 16'hFF80);
    drain();
    op(4'b0100, 3'd4, 16'hABCD, "clrl");
    push("clrl_R2", 0, 2, 16'h00CD);
    drain();
    op(4'b0001, 3'd5, 16'h00EE, "wrl");
    drain();

    @(negedge Clock);
    RegEn = 4'b1000; FunSel = 3'd0; I = '0; OutASel = 2'd3; OutBSel = 2'd3;
    #1;
`ifdef REG_BANK_FWD_EN
    chk("fwd_pre_edge_A", OutA, 16'hFFFF);
    chk("fwd_pre_edge_B", OutB, 16'hFFFF);
`else
    chk("nofwd_pre_edge_A", OutA, 16'h0000);
    chk("nofwd_pre_edge_B", OutB, 16'h0000);
`endif
    @(posedge Clock);
    #1 RegEn = '0;
    m[3] = 16'hFFFF; mw = 1'b1;
    push("dec_R3", 0, 3, 16'hFFFF);
    push("dec_wrap", 2, 0, 16'h0001);
    push_model("dec");
    drain();

    @(negedge Clock);
    RegEn = 4'b0011; FunSel = 3'd2; I = 16'h5A5A;
    #3 Reset = 1'b1;
    @(posedge Clock);
    #1 RegEn = '0;
    model_reset();
    push("rst_edge_R0", 0, 0, 16'h0000);
    push("rst_edge_R1", 1, 1, 16'h0000);
    push("rst_edge_wrap", 2, 0, 16'h0000);
    drain();
    @(negedge Clock);
    Reset = 1'b0;

    op(4'b1001, 3'd1, 16'h0000, "post_rst_inc");
    push("post_rst_inc_R0", 0, 0, 16'h0001);
    push("post_rst_inc_R3", 1, 3, 16'h0001);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
